// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 constants, exception codes and sequencer states
// Purpose: index map of the CP0 register bank, ExcCode values, FSM encoding
//          and the EPC selection helper used by the exception sequencer.
// Ports:   none (package).
package cp0_pkg;

  // CP0 register indices as seen by mtc0/mfc0
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // ExcCode values composed into Cause[6:2] by the upstream cause logic
  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_RI  = 5'h0a;
  localparam logic [4:0] EXC_OV  = 5'h0c;

  // Status keeps only IM[15:8], EXL[1] and IE[0]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_EXC  = 2'd1,
    S_ERET = 2'd2
  } cp0_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - CP0 register access bus (mtc0 write / mfc0 read)
// Purpose: groups the coprocessor-0 move-to / move-from signals.
// Ports:   mtc0_we, mtc0_addr, mtc0_data  write side (master drives)
//          mfc0_addr                      read index (master drives)
//          mfc0_data                      read data  (slave drives, combinational)
interface cp0_exc_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              mtc0_we;
  logic [ADDR_W-1:0] mtc0_addr;
  logic [31:0]       mtc0_data;
  logic [ADDR_W-1:0] mfc0_addr;
  logic [31:0]       mfc0_data;

  modport master (
    output mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
    input  mfc0_data
  );

  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
    output mfc0_data
  );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare timer with sticky interrupt request
// Purpose: free-running Count, software Compare, timer_int raised the cycle
//          after Count==Compare (Compare!=0) and cleared by any Compare write.
// Ports:   clk, rst        clock, async active-high reset
//          wr_count        load Count from wr_data this cycle
//          wr_compare      load Compare from wr_data this cycle (clears timer_int)
//          wr_data         write data
//          count, compare  current register values
//          timer_int       interrupt request
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      // Natural 32-bit wrap from FFFF_FFFF to 0
      count <= wr_count ? wr_data : (count + 32'd1);
      if (wr_compare) begin
        compare <= wr_data;
      end
      // Compare write acknowledges the interrupt and takes priority over a match
      if (wr_compare) begin
        timer_int <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 register bank and exception/ERET redirect sequencer
// Purpose: holds Status/Cause/EPC (Count/Compare when CP0_TIMER_EN is defined),
//          saves EPC and sets EXL on exception entry, and issues a one-cycle
//          registered redirect+flush to EXC_VECTOR (exception) or EPC (ERET).
// Config:  CP0_TIMER_EN defined   -> cp0_timer instantiated, Count/Compare live
//          CP0_TIMER_EN undefined -> Count/Compare read 0, timer_int tied 0
// Ports:   clk, rst                async active-high reset
//          cause_in                next Cause value (reloaded every cycle)
//          exc_req, exc_pc, exc_bd exception request, its PC, delay-slot flag
//          eret                    ERET retiring
//          bus                     mtc0/mfc0 register access (slave)
//          cause_out, status_out, epc_out, EXL, int_pending, timer_int
//          redirect, redirect_pc, flush  registered fetch redirect
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int          CP0_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   cause_in,
  input  logic          exc_req,
  input  logic [31:0]   exc_pc,
  input  logic          exc_bd,
  input  logic          eret,
  cp0_exc_ctrl_if.slave bus,
  output logic [31:0]   cause_out,
  output logic [31:0]   status_out,
  output logic [31:0]   epc_out,
  output logic          EXL,
  output logic          int_pending,
  output logic          timer_int,
  output logic          redirect,
  output logic [31:0]   redirect_pc,
  output logic          flush
);

  cp0_state_e  state;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] rd_data;

  // Requests are only honoured in S_RUN; the other states are the flushed bubble
  logic accept;
  logic take_exc;
  logic take_eret;
  logic wr_ok;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic [31:0] eret_target;

  assign accept    = (state == S_RUN);
  assign take_exc  = accept & exc_req;
  assign take_eret = accept & eret & ~exc_req;
  assign wr_ok     = accept & bus.mtc0_we & ~exc_req;
  assign wr_status = wr_ok & (bus.mtc0_addr == CP0_ADDR_W'(CP0_STATUS));
  assign wr_cause  = wr_ok & (bus.mtc0_addr == CP0_ADDR_W'(CP0_CAUSE));
  assign wr_epc    = wr_ok & (bus.mtc0_addr == CP0_ADDR_W'(CP0_EPC));

  // A same-cycle mtc0 to EPC is where ERET must return to
  assign eret_target = wr_epc ? bus.mtc0_data : epc_q;

  // Register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 32'd0;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      // Only the software-writable IP[1:0] bits may be overridden by mtc0
      cause_q <= wr_cause ? {cause_in[31:10], bus.mtc0_data[9:8], cause_in[7:0]}
                          : cause_in;
      if (wr_status) begin
        status_q <= bus.mtc0_data & STATUS_WMASK;
      end
      if (wr_epc) begin
        epc_q <= bus.mtc0_data;
      end
      if (take_exc) begin
        // Nested exception keeps the original return address
        if (!status_q[1]) begin
          epc_q <= epc_of(exc_pc, exc_bd);
        end
        status_q[1] <= 1'b1;
      end else if (take_eret) begin
        status_q[1] <= 1'b0;
      end
    end
  end

  // Redirect sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      redirect    <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (take_exc) begin
            state       <= S_EXC;
            redirect    <= 1'b1;
            flush       <= 1'b1;
            redirect_pc <= EXC_VECTOR;
          end else if (take_eret) begin
            state       <= S_ERET;
            redirect    <= 1'b1;
            flush       <= 1'b1;
            redirect_pc <= eret_target;
          end else begin
            redirect <= 1'b0;
            flush    <= 1'b0;
          end
        end
        S_EXC, S_ERET: begin
          state    <= S_RUN;
          redirect <= 1'b0;
          flush    <= 1'b0;
        end
        default: begin
          state    <= S_RUN;
          redirect <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  logic wr_count;
  logic wr_compare;

  assign wr_count   = wr_ok & (bus.mtc0_addr == CP0_ADDR_W'(CP0_COUNT));
  assign wr_compare = wr_ok & (bus.mtc0_addr == CP0_ADDR_W'(CP0_COMPARE));

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_count),
    .wr_compare (wr_compare),
    .wr_data    (bus.mtc0_data),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );
`else
  assign count     = 32'd0;
  assign compare   = 32'd0;
  assign timer_int = 1'b0;
`endif

  // mfc0 read, no bypass of same-cycle writes
  always_comb begin
    rd_data = 32'd0;
    if (bus.mfc0_addr == CP0_ADDR_W'(CP0_COUNT)) begin
      rd_data = count;
    end else if (bus.mfc0_addr == CP0_ADDR_W'(CP0_COMPARE)) begin
      rd_data = compare;
    end else if (bus.mfc0_addr == CP0_ADDR_W'(CP0_STATUS)) begin
      rd_data = status_q;
    end else if (bus.mfc0_addr == CP0_ADDR_W'(CP0_CAUSE)) begin
      rd_data = cause_q;
    end else if (bus.mfc0_addr == CP0_ADDR_W'(CP0_EPC)) begin
      rd_data = epc_q;
    end
  end

  assign bus.mfc0_data = rd_data;
  assign cause_out     = cause_q;
  assign status_out    = status_q;
  assign epc_out       = epc_q;
  assign EXL           = status_q[1];
  assign int_pending   = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cause_in;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic [31:0] cause_out, status_out, epc_out, redirect_pc;
  logic        exl, int_pending, timer_int, redirect, flush;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cause_in    (cause_in),
    .exc_req     (exc_req),
    .exc_pc      (exc_pc),
    .exc_bd      (exc_bd),
    .eret        (eret),
    .bus         (bus),
    .cause_out   (cause_out),
    .status_out  (status_out),
    .epc_out     (epc_out),
    .EXL         (exl),
    .int_pending (int_pending),
    .timer_int   (timer_int),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural registers plus "redirect in flight"
  logic [31:0] m_status, m_cause, m_epc, m_rpc, m_count, m_compare;
  logic        m_redir, m_tint;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      CP0_COUNT:   return m_count;
      CP0_COMPARE: return m_compare;
      CP0_STATUS:  return m_status;
      CP0_CAUSE:   return m_cause;
      CP0_EPC:     return m_epc;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic m_pending();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
  endfunction

  task automatic model_clear();
    m_status = 0; m_cause = 0; m_epc = 0; m_rpc = 0;
    m_count = 0; m_compare = 0; m_redir = 0; m_tint = 0;
  endtask

  task automatic idle();
    exc_req = 0; eret = 0; exc_bd = 0; exc_pc = 0;
    bus.mtc0_we = 0; bus.mtc0_addr = 0; bus.mtc0_data = 0; bus.mfc0_addr = 0;
  endtask

  task automatic apply_reset();
    idle();
    cause_in = 0;
    rst = 1;
    model_clear();
    @(posedge clk);
    #1 rst = 0;
  endtask

  // One clock: model applies the rules to the current inputs, DUT clocks
  task automatic cycle();
    logic [31:0] n_status, n_cause, n_epc, n_rpc, n_count, n_compare;
    logic        n_redir, n_tint, busy;
`ifdef CP0_TIMER_EN
    logic        wr_cnt, wr_cmp;
    wr_cnt = 0; wr_cmp = 0;
`endif
    n_status = m_status; n_epc = m_epc; n_rpc = m_rpc;
    n_count = m_count; n_compare = m_compare; n_tint = m_tint;
    n_cause = cause_in;
    n_redir = 0;
    busy = m_redir;
    if (!busy && exc_req) begin
      if (!m_status[1]) n_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
      n_status[1] = 1'b1;
      n_redir = 1; n_rpc = 32'h180;
    end else if (!busy) begin
      if (bus.mtc0_we) begin
        case (bus.mtc0_addr)
          CP0_STATUS: n_status = bus.mtc0_data & 32'h0000_FF03;
          CP0_CAUSE:  n_cause[9:8] = bus.mtc0_data[9:8];
          CP0_EPC:    n_epc = bus.mtc0_data;
`ifdef CP0_TIMER_EN
          CP0_COUNT:   wr_cnt = 1;
          CP0_COMPARE: wr_cmp = 1;
`endif
          default: ;
        endcase
      end
      if (eret) begin
        n_status[1] = 1'b0;
        n_redir = 1; n_rpc = n_epc;
      end
    end
`ifdef CP0_TIMER_EN
    n_count = wr_cnt ? bus.mtc0_data : m_count + 32'd1;
    if (wr_cmp) n_compare = bus.mtc0_data;
    if (wr_cmp) n_tint = 0;
    else if (m_count == m_compare && m_compare != 0) n_tint = 1;
`endif
    @(posedge clk);
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_rpc = n_rpc;
    m_count = n_count; m_compare = n_compare; m_redir = n_redir; m_tint = n_tint;
    #1;
  endtask

  task automatic test_reset();
    idle();
    cause_in = 32'hFFFF_FFFF;
    rst = 1;
    #1;
    total++; if (redirect !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b/%b want=0/0", redirect, flush); end
    total++; if (status_out !== 32'd0 || epc_out !== 32'd0) begin bad++; $display("FAIL reset_regs status=%h epc=%h want=0", status_out, epc_out); end
    total++; if (redirect_pc !== 32'd0 || timer_int !== 1'b0) begin bad++; $display("FAIL reset_pc_tint pc=%h tint=%b want=0", redirect_pc, timer_int); end
    @(posedge clk);
    #1;
    total++; if (cause_out !== 32'd0) begin bad++; $display("FAIL reset_cause got=%h want=0", cause_out); end
    rst = 0;
    cause_in = 0;
    model_clear();
  endtask

  task automatic test_exception();
    apply_reset();
    exc_req = 1; exc_pc = 32'h40; exc_bd = 0;
    cycle();
    idle();
    total++; if (epc_out !== 32'h40 || exl !== 1'b1) begin bad++; $display("FAIL exc_entry epc=%h exl=%b want=40/1", epc_out, exl); end
    total++; if (redirect !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h180) begin bad++; $display("FAIL exc_redirect r=%b f=%b pc=%h want=1/1/180", redirect, flush, redirect_pc); end
    cycle();
    total++; if (redirect !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL exc_redirect_drop r=%b f=%b want=0/0", redirect, flush); end
  endtask

  task automatic test_bd_nested();
    apply_reset();
    exc_req = 1; exc_pc = 32'h104; exc_bd = 1;
    cycle();
    idle();
    total++; if (epc_out !== 32'h100) begin bad++; $display("FAIL bd_epc got=%h want=100", epc_out); end
    cycle();
    exc_req = 1; exc_pc = 32'h200; exc_bd = 0;
    cycle();
    idle();
    total++; if (epc_out !== 32'h100 || redirect !== 1'b1 || redirect_pc !== 32'h180) begin bad++; $display("FAIL nested_epc epc=%h r=%b pc=%h want=100/1/180", epc_out, redirect, redirect_pc); end
    // requests during the bubble cycle are ignored
    exc_req = 1; exc_pc = 32'h300;
    bus.mtc0_we = 1; bus.mtc0_addr = CP0_EPC; bus.mtc0_data = 32'h777;
    cycle();
    idle();
    total++; if (epc_out !== 32'h100 || redirect !== 1'b0) begin bad++; $display("FAIL bubble_ignore epc=%h r=%b want=100/0", epc_out, redirect); end
  endtask

  task automatic test_eret();
    apply_reset();
    exc_req = 1; exc_pc = 32'h40;
    cycle(); idle(); cycle();
    eret = 1;
    cycle();
    idle();
    total++; if (exl !== 1'b0 || redirect !== 1'b1 || redirect_pc !== 32'h40) begin bad++; $display("FAIL eret exl=%b r=%b pc=%h want=0/1/40", exl, redirect, redirect_pc); end
    cycle();
    eret = 1; exc_req = 1; exc_pc = 32'h80;
    cycle();
    idle();
    total++; if (redirect_pc !== 32'h180 || exl !== 1'b1 || epc_out !== 32'h80) begin bad++; $display("FAIL eret_vs_exc pc=%h exl=%b epc=%h want=180/1/80", redirect_pc, exl, epc_out); end
    cycle();
    eret = 1; bus.mtc0_we = 1; bus.mtc0_addr = CP0_EPC; bus.mtc0_data = 32'h300;
    cycle();
    idle();
    total++; if (redirect_pc !== 32'h300 || epc_out !== 32'h300) begin bad++; $display("FAIL eret_new_epc pc=%h epc=%h want=300/300", redirect_pc, epc_out); end
    cycle();
    exc_req = 1; exc_pc = 32'h500; bus.mtc0_we = 1; bus.mtc0_addr = CP0_STATUS; bus.mtc0_data = 32'h0000_FF01;
    cycle();
    idle();
    total++; if (status_out !== 32'h2 || epc_out !== 32'h500) begin bad++; $display("FAIL exc_drops_mtc0 status=%h epc=%h want=2/500", status_out, epc_out); end
  endtask

  task automatic test_int_pending();
    apply_reset();
    cause_in = 32'h400;
    bus.mtc0_we = 1; bus.mtc0_addr = CP0_STATUS; bus.mtc0_data = 32'h0000_0401;
    cycle();
    total++; if (int_pending !== 1'b1) begin bad++; $display("FAIL int_pending got=%b want=1", int_pending); end
    bus.mtc0_data = 32'h0000_0403; bus.mfc0_addr = CP0_STATUS;
    #1;
    total++; if (bus.mfc0_data !== 32'h401) begin bad++; $display("FAIL mfc0_no_bypass got=%h want=401", bus.mfc0_data); end
    cycle();
    total++; if (int_pending !== 1'b0 || exl !== 1'b1) begin bad++; $display("FAIL int_masked_exl pend=%b exl=%b want=0/1", int_pending, exl); end
    bus.mtc0_data = 32'hFFFF_FFFF;
    cycle();
    bus.mtc0_we = 0;
    #1;
    total++; if (bus.mfc0_data !== 32'h0000_FF03) begin bad++; $display("FAIL status_mask got=%h want=ff03", bus.mfc0_data); end
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd5; bus.mtc0_data = 32'h1234; bus.mfc0_addr = 5'd5;
    cycle();
    total++; if (bus.mfc0_data !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h want=0", bus.mfc0_data); end
    bus.mtc0_addr = CP0_CAUSE; bus.mtc0_data = 32'hFFFF_FFFF; cause_in = 32'h0000_0001;
    cycle();
    idle();
    total++; if (cause_out !== 32'h0000_0301) begin bad++; $display("FAIL cause_sw_bits got=%h want=301", cause_out); end
    cause_in = 0;
    cycle();
  endtask

  task automatic test_timer();
    logic rose;
    apply_reset();
`ifdef CP0_TIMER_EN
    bus.mtc0_we = 1; bus.mtc0_addr = CP0_COMPARE; bus.mtc0_data = 32'd5;
    cycle();
    idle();
    rose = 0;
    for (int i = 0; i < 20 && !rose; i++) begin
      cycle();
      rose = timer_int;
    end
    bus.mfc0_addr = CP0_COUNT;
    #1;
    total++; if (rose !== 1'b1 || bus.mfc0_data !== 32'd6) begin bad++; $display("FAIL timer_rise rose=%b count=%0d want=1/6", rose, bus.mfc0_data); end
    bus.mtc0_we = 1; bus.mtc0_addr = CP0_COMPARE; bus.mtc0_data = 32'd20;
    cycle();
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b want=0", timer_int); end
    bus.mtc0_addr = CP0_COUNT; bus.mtc0_data = 32'hFFFF_FFFF;
    cycle();
    bus.mtc0_we = 0;
    cycle();
    #1;
    total++; if (bus.mfc0_data !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h want=0", bus.mfc0_data); end
    idle();
`else
    bus.mtc0_we = 1; bus.mtc0_addr = CP0_COMPARE; bus.mtc0_data = 32'd5;
    cycle();
    bus.mtc0_addr = CP0_COUNT;
    cycle();
    idle();
    rose = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      rose = rose | timer_int;
    end
    total++; if (rose !== 1'b0) begin bad++; $display("FAIL timer_tied got=%b want=0", rose); end
    bus.mfc0_addr = CP0_COUNT;
    #1;
    total++; if (bus.mfc0_data !== 32'd0) begin bad++; $display("FAIL count_absent got=%h want=0", bus.mfc0_data); end
    bus.mfc0_addr = CP0_COMPARE;
    #1;
    total++; if (bus.mfc0_data !== 32'd0) begin bad++; $display("FAIL compare_absent got=%h want=0", bus.mfc0_data); end
    idle();
`endif
  endtask

  task automatic test_reset_mid_redirect();
    apply_reset();
    bus.mtc0_we = 1; bus.mtc0_addr = CP0_STATUS; bus.mtc0_data = 32'h0000_0101;
    cycle();
    idle();
    exc_req = 1; exc_pc = 32'h40;
    cycle();
    idle();
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL pre_reset_redirect got=%b want=1", redirect); end
    #2 rst = 1;
    #1;
    total++; if (redirect !== 1'b0 || flush !== 1'b0 || status_out !== 32'd0 || epc_out !== 32'd0) begin bad++; $display("FAIL reset_mid_exc r=%b f=%b status=%h epc=%h want=0", redirect, flush, status_out, epc_out); end
    model_clear();
    @(posedge clk);
    #1 rst = 0;
    cycle();
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL no_redirect_after_reset got=%b want=0", redirect); end
  endtask

  task automatic test_random();
    logic [4:0] idx [6];
    idx[0] = CP0_COUNT; idx[1] = CP0_COMPARE; idx[2] = CP0_STATUS;
    idx[3] = CP0_CAUSE; idx[4] = CP0_EPC;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      idx[5] = 5'($urandom);
      cause_in      = $urandom;
      exc_req       = ($urandom_range(0, 9) < 2);
      eret          = ($urandom_range(0, 3) == 0);
      exc_pc        = $urandom & 32'hFFFF_FFFC;
      exc_bd        = 1'($urandom);
      bus.mtc0_we   = 1'($urandom);
      bus.mtc0_addr = idx[$urandom_range(0, 5)];
      bus.mtc0_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.mfc0_addr = idx[$urandom_range(0, 5)];
      #1;
      total++; if (bus.mfc0_data !== m_read(bus.mfc0_addr)) begin bad++; $display("FAIL rnd_mfc0 n=%0d idx=%0d got=%h want=%h", n, bus.mfc0_addr, bus.mfc0_data, m_read(bus.mfc0_addr)); end
      total++; if (int_pending !== m_pending()) begin bad++; $display("FAIL rnd_int_pending n=%0d got=%b want=%b", n, int_pending, m_pending()); end
      cycle();
      total++; if (redirect !== m_redir || flush !== m_redir) begin bad++; $display("FAIL rnd_redirect n=%0d r=%b f=%b want=%b", n, redirect, flush, m_redir); end
      if (m_redir) begin
        total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL rnd_redirect_pc n=%0d got=%h want=%h", n, redirect_pc, m_rpc); end
      end
      total++; if (status_out !== m_status || exl !== m_status[1]) begin bad++; $display("FAIL rnd_status n=%0d got=%h want=%h", n, status_out, m_status); end
      total++; if (cause_out !== m_cause) begin bad++; $display("FAIL rnd_cause n=%0d got=%h want=%h", n, cause_out, m_cause); end
      total++; if (epc_out !== m_epc) begin bad++; $display("FAIL rnd_epc n=%0d got=%h want=%h", n, epc_out, m_epc); end
      total++; if (timer_int !== m_tint) begin bad++; $display("FAIL rnd_timer_int n=%0d got=%b want=%b", n, timer_int, m_tint); end
    end
    idle();
  endtask

  initial begin
    rst = 1;
    cause_in = 0;
    idle();
    model_clear();
    test_reset();
    test_exception();
    test_bd_nested();
    test_eret();
    test_int_pending();
    test_timer();
    test_reset_mid_redirect();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
